mem_arbiter: RTL

// Two-requester arbiter and sequencer in front of the DDR3 memory block's mux_mem port.

---
 rtl/mem_arbiter.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and command sequencer for the DDR3 mux_mem port.
// One transaction in flight at a time: grant, issue strobe, optionally wait for read data
// (with timeout), then pulse a registered ack back to the granted requester.

// Per-requester response register: ack pulse plus sticky rdata/err until the next ack.
module mem_arb_rsp (
    input  logic        clk,
    input  logic        rst,
    input  logic        set,
    input  logic [31:0] set_rdata,
    input  logic        set_err,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    // ack is a single-cycle pulse; rdata/err only change when a new response lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack   <= 1'b0;
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            ack <= set;
            if (set) begin
                rdata <= set_rdata;
                err   <= set_err;
            end
        end
    end

endmodule

module mem_arbiter #(
    parameter int ADDR_WIDTH     = 27,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [1:0]            req0_width,
    input  logic [31:0]           req0_wdata,
    output logic                  req0_ack,
    output logic [31:0]           req0_rdata,
    output logic                  req0_err,

    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [1:0]            req1_width,
    input  logic [31:0]           req1_wdata,
    output logic                  req1_ack,
    output logic [31:0]           req1_rdata,
    output logic                  req1_err,

    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [1:0]            mem_data_width,
    output logic [31:0]           mem_wr_data,
    input  logic                  mem_rd_ready,
    input  logic                  mem_wr_ready,
    input  logic [31:0]           mem_rd_data,
    input  logic                  mem_rd_valid,

    output logic                  busy,
    output logic                  grant_id
);

    localparam int NUM_REQ = 2;
    localparam int CNT_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [1:0]            width;
        logic [31:0]           wdata;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DRAIN} state_t;

    state_t state, state_nxt;

    req_t [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        cand;
    logic [NUM_REQ-1:0]        rsp_set;
    logic [NUM_REQ-1:0]        rsp_ack;
    logic [NUM_REQ-1:0][31:0]  rsp_rdata;
    logic [NUM_REQ-1:0]        rsp_err;

    logic             last_grant;
    logic [CNT_W-1:0] cnt;

    logic        grant_fire;
    logic        grant_sel;
    logic        rsp_fire;
    logic        rsp_sel;
    logic [31:0] rsp_rdata_nxt;
    logic        rsp_err_nxt;
    logic        strobe_drop;
    logic        cnt_clr;
    logic        cnt_inc;

    assign req[0]       = {req0_we, req0_addr, req0_width, req0_wdata};
    assign req[1]       = {req1_we, req1_addr, req1_width, req1_wdata};
    assign req_valid    = {req1_valid, req0_valid};

    // A requester whose ack is on the wire this cycle still shows valid; keep it out.
    assign cand         = req_valid & ~rsp_ack;

    assign busy         = (state != IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, grant decision and response/counter controls
    always_comb begin
        state_nxt     = state;
        grant_fire    = 1'b0;
        grant_sel     = 1'b0;
        rsp_fire      = 1'b0;
        rsp_sel       = grant_id;
        rsp_rdata_nxt = '0;
        rsp_err_nxt   = 1'b0;
        strobe_drop   = 1'b0;
        cnt_clr       = 1'b0;
        cnt_inc       = 1'b0;
        case (state)
            IDLE: begin
                if (|cand) begin
                    grant_fire = 1'b1;
                    grant_sel  = (&cand) ? ~last_grant : cand[1];
                    if (req[grant_sel].width != 2'b00) begin
                        state_nxt = ISSUE;
                    end else begin
                        // zero-width access completes without touching memory
                        rsp_fire = 1'b1;
                        rsp_sel  = grant_sel;
                    end
                end
            end
            ISSUE: begin
                if (mem_wr && mem_wr_ready) begin
                    strobe_drop = 1'b1;
                    rsp_fire    = 1'b1;
                    state_nxt   = IDLE;
                end else if (mem_rd && mem_rd_ready) begin
                    strobe_drop = 1'b1;
                    cnt_clr     = 1'b1;
                    state_nxt   = WAIT_RD;
                end
            end
            WAIT_RD: begin
                // data arriving on the terminal count still wins over the timeout
                if (mem_rd_valid) begin
                    rsp_fire      = 1'b1;
                    rsp_rdata_nxt = mem_rd_data;
                    state_nxt     = IDLE;
                end else if (cnt == CNT_LAST) begin
                    rsp_fire    = 1'b1;
                    rsp_err_nxt = 1'b1;
                    cnt_clr     = 1'b1;
                    state_nxt   = DRAIN;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DRAIN: begin
                // swallow the late response of the timed-out read, or give up after another window
                if (mem_rd_valid || cnt == CNT_LAST) begin
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latched command, strobes, grant bookkeeping and response counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rd         <= 1'b0;
            mem_wr         <= 1'b0;
            mem_addr       <= '0;
            mem_data_width <= '0;
            mem_wr_data    <= '0;
            grant_id       <= 1'b0;
            last_grant     <= 1'b1;
            cnt            <= '0;
        end else begin
            if (grant_fire) begin
                grant_id       <= grant_sel;
                last_grant     <= grant_sel;
                mem_addr       <= req[grant_sel].addr;
                mem_data_width <= req[grant_sel].width;
                mem_wr_data    <= req[grant_sel].wdata;
                if (req[grant_sel].width != 2'b00) begin
                    mem_rd <= ~req[grant_sel].we;
                    mem_wr <=  req[grant_sel].we;
                end
            end
            if (strobe_drop) begin
                mem_rd <= 1'b0;
                mem_wr <= 1'b0;
            end
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
        end
    end

    assign rsp_set = rsp_fire ? (NUM_REQ'(1) << rsp_sel) : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            mem_arb_rsp u_rsp (
                .clk       (clk),
                .rst       (rst),
                .set       (rsp_set[gi]),
                .set_rdata (rsp_rdata_nxt),
                .set_err   (rsp_err_nxt),
                .ack       (rsp_ack[gi]),
                .rdata     (rsp_rdata[gi]),
                .err       (rsp_err[gi])
            );
        end
    endgenerate

    assign req0_ack   = rsp_ack[0];
    assign req0_rdata = rsp_rdata[0];
    assign req0_err   = rsp_err[0];
    assign req1_ack   = rsp_ack[1];
    assign req1_rdata = rsp_rdata[1];
    assign req1_err   = rsp_err[1];

endmodule
